// File: rtl/ptp_bridge_dbg_cntr_bank_if.sv
// Indexed read port of the debug counter bank: one request per cycle,
// response one cycle later, no backpressure.
interface ptp_bridge_dbg_cntr_bank_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int CNTR_WIDTH = 32
) ();
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_valid;
    logic [CNTR_WIDTH-1:0] rd_data;
    logic                  rd_err;

    modport master (
        output rd_req,
        output rd_addr,
        input  rd_valid,
        input  rd_data,
        input  rd_err
    );

    modport slave (
        input  rd_req,
        input  rd_addr,
        output rd_valid,
        output rd_data,
        output rd_err
    );
endinterface

// File: rtl/ptp_bridge_dbg_cntr_bank.sv
// Bank of PTP bridge debug event counters with wrap/saturate, sticky overflow and indexed reads.
// Define PTP_BRIDGE_DBG_CNTR_SNAPSHOT_EN to build shadow registers; reads then return the last snapshot.
module ptp_bridge_dbg_cntr_bank #(
    parameter int CNTR_WIDTH = 32,
    parameter int NUM_CNTR   = 8,
    parameter int INC_WIDTH  = 4,
    parameter int SATURATE   = 0,
    parameter int ADDR_WIDTH = (NUM_CNTR > 1) ? $clog2(NUM_CNTR) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CNTR-1:0]           inc_valid,
    input  logic [NUM_CNTR*INC_WIDTH-1:0] inc_val,
    input  logic                          clear_all,
    input  logic                          snapshot,
    output logic [NUM_CNTR-1:0]           ovf,
    ptp_bridge_dbg_cntr_bank_if.slave     rd
);

    // Per-counter value presented to the read mux (shadow or live).
    logic [CNTR_WIDTH-1:0] src_vec [NUM_CNTR];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CNTR; gi++) begin : g_cntr
            logic [CNTR_WIDTH-1:0] cnt_reg;
            logic                  ovf_reg;
            logic [CNTR_WIDTH:0]   sum;

            // One extra bit so the carry out of the counter width is visible.
            assign sum = {1'b0, cnt_reg}
                       + {{(CNTR_WIDTH + 1 - INC_WIDTH){1'b0}}, inc_val[gi*INC_WIDTH +: INC_WIDTH]};

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg <= '0;
                    ovf_reg <= 1'b0;
                end else if (clear_all) begin
                    cnt_reg <= '0;
                    ovf_reg <= 1'b0;
                end else if (inc_valid[gi]) begin
                    if (sum[CNTR_WIDTH]) begin
                        ovf_reg <= 1'b1;
                        cnt_reg <= (SATURATE != 0) ? {CNTR_WIDTH{1'b1}} : sum[CNTR_WIDTH-1:0];
                    end else begin
                        cnt_reg <= sum[CNTR_WIDTH-1:0];
                    end
                end
            end

            assign ovf[gi] = ovf_reg;

`ifdef PTP_BRIDGE_DBG_CNTR_SNAPSHOT_EN
            logic [CNTR_WIDTH-1:0] shadow_reg;

            // Captures the pre-increment, pre-clear value of the snapshot cycle.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    shadow_reg <= '0;
                end else if (snapshot) begin
                    shadow_reg <= cnt_reg;
                end
            end

            assign src_vec[gi] = shadow_reg;
`else
            assign src_vec[gi] = cnt_reg;
`endif
        end
    endgenerate

`ifndef PTP_BRIDGE_DBG_CNTR_SNAPSHOT_EN
    logic unused_snapshot;
    assign unused_snapshot = snapshot;
`endif

    logic                  addr_err;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic                  rd_valid_reg;
    logic [CNTR_WIDTH-1:0] rd_data_reg;
    logic                  rd_err_reg;

    assign addr_err = ({1'b0, rd.rd_addr} >= (ADDR_WIDTH + 1)'(NUM_CNTR));
    // Keep the array index in range even for a bad address.
    assign rd_idx   = addr_err ? '0 : rd.rd_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
            rd_err_reg   <= 1'b0;
        end else begin
            rd_valid_reg <= rd.rd_req;
            if (rd.rd_req) begin
                rd_data_reg <= addr_err ? '0 : src_vec[rd_idx];
                rd_err_reg  <= addr_err;
            end
        end
    end

    assign rd.rd_valid = rd_valid_reg;
    assign rd.rd_data  = rd_data_reg;
    assign rd.rd_err   = rd_err_reg;

endmodule

// File: tb/tb_ptp_bridge_dbg_cntr_bank.sv
// Self-checking bench: a wrapping (dut0) and a saturating (dut1) 8-bit, 6-counter bank,
// read responses scored against a queue of model expectations.
module tb_ptp_bridge_dbg_cntr_bank;

`ifdef PTP_BRIDGE_DBG_CNTR_SNAPSHOT_EN
    localparam bit SNAP_EN = 1'b1;
`else
    localparam bit SNAP_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       err;
        int         cyc;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;

    logic [5:0]  inc_valid0 = '0, inc_valid1 = '0;
    logic [23:0] inc_val0 = '0, inc_val1 = '0;
    logic        clear_all0 = 1'b0, clear_all1 = 1'b0;
    logic        snapshot0 = 1'b0, snapshot1 = 1'b0;
    logic [5:0]  ovf0, ovf1;

    ptp_bridge_dbg_cntr_bank_if #(.ADDR_WIDTH(3), .CNTR_WIDTH(8)) ri0 ();
    ptp_bridge_dbg_cntr_bank_if #(.ADDR_WIDTH(3), .CNTR_WIDTH(8)) ri1 ();

    ptp_bridge_dbg_cntr_bank #(.CNTR_WIDTH(8), .NUM_CNTR(6), .INC_WIDTH(4), .SATURATE(0)) dut0 (
        .clk(clk), .rst(rst), .inc_valid(inc_valid0), .inc_val(inc_val0),
        .clear_all(clear_all0), .snapshot(snapshot0), .ovf(ovf0), .rd(ri0.slave)
    );

    ptp_bridge_dbg_cntr_bank #(.CNTR_WIDTH(8), .NUM_CNTR(6), .INC_WIDTH(4), .SATURATE(1)) dut1 (
        .clk(clk), .rst(rst), .inc_valid(inc_valid1), .inc_val(inc_val1),
        .clear_all(clear_all1), .snapshot(snapshot1), .ovf(ovf1), .rd(ri1.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rsp_t exp_q0[$], exp_q1[$], act_q0[$], act_q1[$];
    rsp_t mon0, mon1;

    // Reference model state: live counters, shadows, sticky flags.
    int         mcnt [2][6];
    int         msh  [2][6];
    logic [5:0] movf [2];

    always @(negedge clk) begin
        if (ri0.rd_valid === 1'b1) begin
            mon0.data = ri0.rd_data; mon0.err = ri0.rd_err; mon0.cyc = cyc;
            act_q0.push_back(mon0);
        end
        if (ri1.rd_valid === 1'b1) begin
            mon1.data = ri1.rd_data; mon1.err = ri1.rd_err; mon1.cyc = cyc;
            act_q1.push_back(mon1);
        end
    end

    function automatic logic [23:0] put(input int slot, input int val);
        logic [23:0] v;
        v = 24'(val & 15) << (slot * 4);
        return v;
    endfunction

    // Drive one cycle of stimulus on dut d, advance the model, queue any read expectation.
    task automatic drive(input int d, input logic [5:0] v, input logic [23:0] vals,
                         input logic clr, input logic snap, input logic req, input int addr);
        rsp_t e;
        int   s;
        if (d == 0) begin
            inc_valid0 = v; inc_val0 = vals; clear_all0 = clr; snapshot0 = snap;
            ri0.rd_req = req; ri0.rd_addr = addr[2:0];
        end else begin
            inc_valid1 = v; inc_val1 = vals; clear_all1 = clr; snapshot1 = snap;
            ri1.rd_req = req; ri1.rd_addr = addr[2:0];
        end
        if (req) begin
            e.err  = (addr >= 6);
            e.data = 8'h00;
            if (addr < 6) e.data = 8'(SNAP_EN ? msh[d][addr] : mcnt[d][addr]);
            e.cyc  = cyc + 1;
            if (d == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
        end
        for (int n = 0; n < 6; n++) if (snap && SNAP_EN) msh[d][n] = mcnt[d][n];
        if (clr) begin
            for (int n = 0; n < 6; n++) mcnt[d][n] = 0;
            movf[d] = '0;
        end else begin
            for (int n = 0; n < 6; n++) begin
                if (v[n]) begin
                    s = mcnt[d][n] + int'(vals[n*4 +: 4]);
                    if (s > 255) begin
                        movf[d][n] = 1'b1;
                        mcnt[d][n] = (d == 1) ? 255 : s - 256;
                    end else begin
                        mcnt[d][n] = s;
                    end
                end
            end
        end
        @(negedge clk);
        if (d == 0) begin
            inc_valid0 = '0; inc_val0 = '0; clear_all0 = 1'b0; snapshot0 = 1'b0; ri0.rd_req = 1'b0;
        end else begin
            inc_valid1 = '0; inc_val1 = '0; clear_all1 = 1'b0; snapshot1 = 1'b0; ri1.rd_req = 1'b0;
        end
    endtask

    // Bounded wait for the next response of dut d, paired with its oldest expectation.
    task automatic get_rsp(input int d, output rsp_t e, output rsp_t a, output bit got);
        got = 1'b0; e = '0; a = '0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (d == 0 && act_q0.size() > 0) begin a = act_q0.pop_front(); got = 1'b1; end
            else if (d == 1 && act_q1.size() > 0) begin a = act_q1.pop_front(); got = 1'b1; end
            else @(negedge clk);
        end
        if (d == 0 && exp_q0.size() > 0) e = exp_q0.pop_front();
        else if (d == 1 && exp_q1.size() > 0) e = exp_q1.pop_front();
    endtask

    task automatic test_reset();
        rsp_t e, a;
        bit   got;
        repeat (2) @(negedge clk);
        checks++;
        if (ri0.rd_valid !== 1'b0 || ri1.rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b/%b, required 0/0", ri0.rd_valid, ri1.rd_valid);
        else passed++;
        checks++;
        if (ri0.rd_data !== 8'h00 || ri1.rd_data !== 8'h00) $display("FAIL reset_rd_data: got %h/%h, required 00/00", ri0.rd_data, ri1.rd_data);
        else passed++;
        checks++;
        if (ri0.rd_err !== 1'b0 || ri1.rd_err !== 1'b0) $display("FAIL reset_rd_err: got %b/%b, required 0/0", ri0.rd_err, ri1.rd_err);
        else passed++;
        checks++;
        if (ovf0 !== 6'h00 || ovf1 !== 6'h00) $display("FAIL reset_ovf: got %h/%h, required 00/00", ovf0, ovf1);
        else passed++;
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            drive(d, '0, '0, 1'b0, 1'b0, 1'b1, 0);
            get_rsp(d, e, a, got);
            checks++;
            if (!got) $display("FAIL reset_rd%0d: no response, required data=%h err=%b", d, e.data, e.err);
            else if (a !== e) $display("FAIL reset_rd%0d: got data=%h err=%b cyc=%0d, required data=%h err=%b cyc=%0d", d, a.data, a.err, a.cyc, e.data, e.err, e.cyc);
            else begin passed++; $display("txn reset dut%0d addr 0 data=%h err=%b", d, a.data, a.err); end
        end
    endtask

    task automatic test_wrap();
        rsp_t e, a;
        bit   got;
        repeat (16) drive(0, 6'b000100, put(2, 15), 1'b0, 1'b0, 1'b0, 0);
        drive(0, 6'b000100, put(2, 13), 1'b0, 1'b0, 1'b0, 0);
        checks++;
        if (ovf0 !== 6'h00) $display("FAIL wrap_no_ovf_at_fd: got ovf=%h, required 00", ovf0);
        else passed++;
        drive(0, 6'b000100, put(2, 5), 1'b0, 1'b0, 1'b0, 0);
        checks++;
        if (ovf0 !== movf[0]) $display("FAIL wrap_ovf: got ovf=%h, required %h", ovf0, movf[0]);
        else passed++;
        drive(0, '0, '0, 1'b0, 1'b1, 1'b0, 0);
        drive(0, '0, '0, 1'b0, 1'b0, 1'b1, 2);
        get_rsp(0, e, a, got);
        checks++;
        if (!got) $display("FAIL wrap_rd: no response, required data=%h", e.data);
        else if (a !== e) $display("FAIL wrap_rd: got data=%h err=%b cyc=%0d, required data=%h err=%b cyc=%0d", a.data, a.err, a.cyc, e.data, e.err, e.cyc);
        else begin passed++; $display("txn wrap cnt2 data=%h", a.data); end
        drive(0, '0, '0, 1'b1, 1'b0, 1'b0, 0);
        checks++;
        if (ovf0 !== 6'h00) $display("FAIL clear_ovf: got ovf=%h, required 00", ovf0);
        else passed++;
        // Clear wins over a same-cycle increment.
        drive(0, 6'b000001, put(0, 3), 1'b1, 1'b0, 1'b0, 0);
        drive(0, '0, '0, 1'b0, 1'b1, 1'b0, 0);
        drive(0, '0, '0, 1'b0, 1'b0, 1'b1, 2);
        drive(0, '0, '0, 1'b0, 1'b0, 1'b1, 0);
        for (int k = 0; k < 2; k++) begin
            get_rsp(0, e, a, got);
            checks++;
            if (!got) $display("FAIL clear_rd%0d: no response, required data=%h", k, e.data);
            else if (a !== e) $display("FAIL clear_rd%0d: got data=%h err=%b cyc=%0d, required data=%h err=%b cyc=%0d", k, a.data, a.err, a.cyc, e.data, e.err, e.cyc);
            else begin passed++; $display("txn clear read %0d data=%h", k, a.data); end
        end
    endtask

    task automatic test_saturate();
        rsp_t e, a;
        bit   got;
        repeat (16) drive(1, 6'b000010, put(1, 15), 1'b0, 1'b0, 1'b0, 0);
        drive(1, 6'b000010, put(1, 14), 1'b0, 1'b0, 1'b0, 0);
        drive(1, 6'b000010, put(1, 15), 1'b0, 1'b0, 1'b0, 0);
        checks++;
        if (ovf1 !== movf[1]) $display("FAIL sat_ovf: got ovf=%h, required %h", ovf1, movf[1]);
        else passed++;
        drive(1, '0, '0, 1'b0, 1'b1, 1'b0, 0);
        drive(1, '0, '0, 1'b0, 1'b0, 1'b1, 1);
        drive(1, 6'b000010, put(1, 1), 1'b0, 1'b0, 1'b0, 0);
        drive(1, '0, '0, 1'b0, 1'b1, 1'b0, 0);
        drive(1, '0, '0, 1'b0, 1'b0, 1'b1, 1);
        for (int k = 0; k < 2; k++) begin
            get_rsp(1, e, a, got);
            checks++;
            if (!got) $display("FAIL sat_rd%0d: no response, required data=%h", k, e.data);
            else if (a !== e || a.data !== 8'hFF) $display("FAIL sat_rd%0d: got data=%h err=%b cyc=%0d, required data=%h err=%b cyc=%0d", k, a.data, a.err, a.cyc, e.data, e.err, e.cyc);
            else begin passed++; $display("txn saturate read %0d data=%h", k, a.data); end
        end
    endtask

    task automatic test_snapshot();
        rsp_t e, a;
        bit   got;
        drive(0, '0, '0, 1'b1, 1'b0, 1'b0, 0);
        drive(0, 6'b001000, put(3, 10), 1'b0, 1'b0, 1'b0, 0);
        drive(0, 6'b001000, put(3, 4), 1'b0, 1'b1, 1'b0, 0);
        drive(0, '0, '0, 1'b0, 1'b0, 1'b1, 3);
        drive(0, '0, '0, 1'b0, 1'b1, 1'b0, 0);
        drive(0, '0, '0, 1'b0, 1'b0, 1'b1, 3);
        drive(0, '0, '0, 1'b1, 1'b1, 1'b0, 0);
        drive(0, '0, '0, 1'b0, 1'b0, 1'b1, 3);
        // Snapshot with a same-cycle read: the read sees the old shadow.
        drive(0, '0, '0, 1'b0, 1'b1, 1'b1, 3);
        drive(0, '0, '0, 1'b0, 1'b0, 1'b1, 3);
        for (int k = 0; k < 5; k++) begin
            get_rsp(0, e, a, got);
            checks++;
            if (!got) $display("FAIL snap_rd%0d: no response, required data=%h", k, e.data);
            else if (a !== e) $display("FAIL snap_rd%0d: got data=%h err=%b cyc=%0d, required data=%h err=%b cyc=%0d", k, a.data, a.err, a.cyc, e.data, e.err, e.cyc);
            else begin passed++; $display("txn snapshot read %0d data=%h", k, a.data); end
        end
    endtask

    task automatic test_back_to_back();
        rsp_t e, a;
        bit   got;
        logic [7:0] last_data;
        last_data = '0;
        drive(0, '0, '0, 1'b1, 1'b0, 1'b0, 0);
        drive(0, 6'b111111, 24'h654321, 1'b0, 1'b0, 1'b0, 0);
        drive(0, '0, '0, 1'b0, 1'b1, 1'b0, 0);
        drive(0, '0, '0, 1'b0, 1'b0, 1'b1, 7);
        for (int i = 0; i < 6; i++) drive(0, '0, '0, 1'b0, 1'b0, 1'b1, i);
        for (int k = 0; k < 7; k++) begin
            get_rsp(0, e, a, got);
            checks++;
            if (!got) $display("FAIL b2b_rd%0d: no response, required data=%h err=%b", k, e.data, e.err);
            else if (a !== e) $display("FAIL b2b_rd%0d: got data=%h err=%b cyc=%0d, required data=%h err=%b cyc=%0d", k, a.data, a.err, a.cyc, e.data, e.err, e.cyc);
            else begin passed++; $display("txn b2b read %0d data=%h err=%b cyc=%0d", k, a.data, a.err, a.cyc); end
            last_data = e.data;
        end
        @(negedge clk);
        checks++;
        if (ri0.rd_valid !== 1'b0 || ri0.rd_data !== last_data || ri0.rd_err !== 1'b0)
            $display("FAIL rd_hold: got valid=%b data=%h err=%b, required valid=0 data=%h err=0", ri0.rd_valid, ri0.rd_data, ri0.rd_err, last_data);
        else passed++;
    endtask

    task automatic test_async_reset();
        rsp_t e, a;
        bit   got;
        ri0.rd_req = 1'b1;
        ri0.rd_addr = 3'd0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (ovf1 !== 6'h00 || ri1.rd_data !== 8'h00) $display("FAIL async_rst_immediate: got ovf1=%h rd_data1=%h, required 00/00", ovf1, ri1.rd_data);
        else passed++;
        @(negedge clk);
        ri0.rd_req = 1'b0;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 6; n++) begin mcnt[d][n] = 0; msh[d][n] = 0; end
            movf[d] = '0;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (act_q0.size() != 0) $display("FAIL async_rst_dropped: got %0d responses, required 0", act_q0.size());
        else passed++;
        drive(1, '0, '0, 1'b0, 1'b1, 1'b0, 0);
        drive(1, '0, '0, 1'b0, 1'b0, 1'b1, 1);
        get_rsp(1, e, a, got);
        checks++;
        if (!got) $display("FAIL async_rst_rd: no response, required data=%h", e.data);
        else if (a !== e) $display("FAIL async_rst_rd: got data=%h err=%b cyc=%0d, required data=%h err=%b cyc=%0d", a.data, a.err, a.cyc, e.data, e.err, e.cyc);
        else begin passed++; $display("txn post-reset read data=%h", a.data); end
    endtask

    initial begin
        ri0.rd_req = 1'b0; ri0.rd_addr = '0;
        ri1.rd_req = 1'b0; ri1.rd_addr = '0;
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 6; n++) begin mcnt[d][n] = 0; msh[d][n] = 0; end
            movf[d] = '0;
        end
        test_reset();
        test_wrap();
        test_saturate();
        test_snapshot();
        test_back_to_back();
        test_async_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (act_q0.size() != 0 || act_q1.size() != 0 || exp_q0.size() != 0 || exp_q1.size() != 0)
            $display("FAIL leftover: got act %0d/%0d exp %0d/%0d, required all 0", act_q0.size(), act_q1.size(), exp_q0.size(), exp_q1.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ptp_bridge_dbg_cntr_bank.md
# ptp_bridge_dbg_cntr_bank

Registered bank of NUM_CNTR debug event counters for the PTP bridge, each accepting a multi-bit increment per cycle, with selectable wrap or saturate mode, sticky overflow flags, global clear, an atomic snapshot, and a one-cycle-latency indexed read port. It sits beside the bridge datapath, counting per-port and per-queue events such as packets, drops and timestamp errors, and feeds the CSR block, which reads the counters by index.

## Interface
- CNTR_WIDTH, 32, counter width in bits (≥ INC_WIDTH+1).
- NUM_CNTR, 8, number of counters (≥1).
- INC_WIDTH, 4, width of per-counter increment amount.
- SATURATE, 0, 0 = wrap modulo 2^CNTR_WIDTH; 1 = hold at all-ones.
- ADDR_WIDTH, $clog2(NUM_CNTR) (min 1), read index width.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  reset; asynchronous, active-high.
- inc_valid  in  NUM_CNTR  per-counter increment strobe.
- inc_val  in  NUM_CNTR×INC_WIDTH  per-counter increment amount; ignored when its strobe is low.
- clear_all  in  1  zeroes all counters and overflow flags.
- snapshot  in  1  captures all live counters into shadow registers.
- rd_req  in  1  read request, one per cycle allowed.
- rd_addr  in  ADDR_WIDTH  counter index for read.
- rd_valid  out  1  read response strobe.
- rd_data  out  CNTR_WIDTH  read value.
- rd_err  out  1  index ≥ NUM_CNTR; qualified by rd_valid.
- ovf  out  NUM_CNTR  sticky overflow flag per counter.

## Operation
- Counter n update when inc_valid[n]=1: next = cnt[n] + zero-extended inc_val[n], computed at CNTR_WIDTH+1 bits.
- Carry out of CNTR_WIDTH bits:
  - SATURATE=0: keep the low CNTR_WIDTH bits (wrap) and set ovf[n].
  - SATURATE=1: load all-ones and set ovf[n].
  - A counter already at all-ones with a nonzero increment sets ovf[n] again, which is harmless.
- inc_val=0 with inc_valid=1: no change, no overflow.
- ovf[n] stays set until clear_all or rst.
- clear_all: next cycle all counters and ovf = 0. clear_all wins over same-cycle increments, which are dropped.
- snapshot: shadow[n] ← current registered cnt[n], which is the pre-increment, pre-clear value of that cycle. Snapshot together with clear_all captures the values before the clear.
- Read: on rd_req, source = shadow[rd_addr] (or live, see Configuration).
  - rd_addr ≥ NUM_CNTR: rd_data = 0, rd_err = 1.
- The read source is sampled in the request cycle from registered state. A read in the same cycle as an increment returns the pre-increment value.
- A snapshot in the same cycle as rd_req: the read returns the old shadow value.

## Timing
- Reset values: all counters, shadows and ovf = 0; rd_valid = 0; rd_data = 0; rd_err = 0.
- Increment, clear or snapshot in cycle T is visible in registers at T+1.
- Read latency: rd_req in cycle T gives rd_valid=1 with rd_data and rd_err in cycle T+1.
- rd_valid is a one-cycle pulse per request. Back-to-back requests give back-to-back responses.
- rd_data and rd_err hold their last value while rd_valid=0.
- No backpressure; the requester must accept the response.
- rst asserted mid-operation clears everything immediately and asynchronously. A request pending at reset assertion produces no response.

## Configuration
- PTP_BRIDGE_DBG_CNTR_SNAPSHOT_EN defined:
  - shadow registers are built;
  - reads return shadow[rd_addr];
  - the snapshot port is functional.
- Undefined:
  - no shadow registers;
  - reads return live cnt[rd_addr];
  - the snapshot port is ignored;
  - all other behaviour is unchanged.

## Test plan
- Reset, then rd_req addr 0: rd_valid at T+1, rd_data=0, rd_err=0, ovf=0.
- CNTR_WIDTH=8, SATURATE=0: cnt[2]=0xFD plus inc_val=5 gives cnt[2]=0x02 and ovf[2]=1. clear_all then gives cnt[2]=0 and ovf[2]=0.
- CNTR_WIDTH=8, SATURATE=1: cnt[1]=0xFE plus inc_val=0xF gives 0xFF and ovf[1]=1. A further increment keeps 0xFF.
- clear_all with inc_valid[0]=1 and inc_val=3 in the same cycle: cnt[0]=0 afterward.
- With _SNAPSHOT_EN:
  - cnt[3]=10, snapshot with inc=4 in the same cycle, read idx 3 returns 10;
  - a second snapshot then read returns 14;
  - snapshot with clear_all captures the pre-clear value.
- NUM_CNTR=6: read addr 7 gives rd_err=1, rd_data=0. Back-to-back reads of idx 0..5 give six consecutive rd_valid pulses in order.
